// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands and control, forwarding inputs, redirect/stall outputs and the EX/MEM register
// outputs of the execute stage. The slave modport is the stage itself; master is the surrounding pipeline.
interface ex_stage_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ALU_CTRL_W = 4
);
    logic                  RegWriteE, MemReadE, MemWriteE;
    logic [2:0]            WriteBackE, funct3E;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic                  ALUSrcAE, ALUSrcBE, BranchE, JumpE, JalrE, MulDivE;
    logic [DATA_W-1:0]     RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]            RdE;
    logic [1:0]            ForwardAE, ForwardBE;
    logic [DATA_W-1:0]     ResultW;

    logic                  PCSrcE;
    logic [DATA_W-1:0]     PCTargetE;
    logic                  StallX;

    logic                  RegWriteM, MemReadM, MemWriteM;
    logic [2:0]            WriteBackM, funct3M;
    logic [DATA_W-1:0]     ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM;
    logic [4:0]            RdM;

    modport slave (
        input  RegWriteE, MemReadE, MemWriteE, WriteBackE, funct3E, ALUControlE,
               ALUSrcAE, ALUSrcBE, BranchE, JumpE, JalrE, MulDivE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, StallX,
               RegWriteM, MemReadM, MemWriteM, WriteBackM, funct3M,
               ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM, RdM
    );

    modport master (
        output RegWriteE, MemReadE, MemWriteE, WriteBackE, funct3E, ALUControlE,
               ALUSrcAE, ALUSrcBE, BranchE, JumpE, JalrE, MulDivE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, StallX,
               RegWriteM, MemReadM, MemWriteM, WriteBackM, funct3M,
               ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM, RdM
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage -- operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Define MULDIV_EN to add an iterative RV32M multiply/divide unit that stalls IF/ID/EX while busy.
module ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ALU_CTRL_W = 4
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    localparam int unsigned SHAMT_W = 5;
    localparam logic [ALU_CTRL_W-1:0] OP_ADD   = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] OP_SUB   = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] OP_AND   = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] OP_OR    = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] OP_XOR   = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] OP_SLL   = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] OP_SRL   = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] OP_SRA   = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] OP_SLT   = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] OP_SLTU  = ALU_CTRL_W'(9);
    localparam logic [ALU_CTRL_W-1:0] OP_PASSB = ALU_CTRL_W'(10);

    logic [DATA_W-1:0]  src_af, src_bf, src_a, src_b, alu_y, ex_result;
    logic [SHAMT_W-1:0] shamt;
    logic               br_taken, stall;

    // Operand forwarding; codes 00 and 11 both select the register-file value.
    always_comb begin
        case (bus.ForwardAE)
            2'b01:   src_af = bus.ResultW;
            2'b10:   src_af = bus.ALUResultM;
            default: src_af = bus.RD1E;
        endcase
        case (bus.ForwardBE)
            2'b01:   src_bf = bus.ResultW;
            2'b10:   src_bf = bus.ALUResultM;
            default: src_bf = bus.RD2E;
        endcase
    end

    assign src_a = bus.ALUSrcAE ? bus.PCE : src_af;
    assign src_b = bus.ALUSrcBE ? bus.ImmExtE : src_bf;
    assign shamt = src_b[SHAMT_W-1:0];

    always_comb begin
        alu_y = '0;
        case (bus.ALUControlE)
            OP_ADD:   alu_y = src_a + src_b;
            OP_SUB:   alu_y = src_a - src_b;
            OP_AND:   alu_y = src_a & src_b;
            OP_OR:    alu_y = src_a | src_b;
            OP_XOR:   alu_y = src_a ^ src_b;
            OP_SLL:   alu_y = src_a << shamt;
            OP_SRL:   alu_y = src_a >> shamt;
            OP_SRA:   alu_y = DATA_W'($signed(src_a) >>> shamt);
            OP_SLT:   alu_y = DATA_W'($signed(src_a) < $signed(src_b));
            OP_SLTU:  alu_y = DATA_W'(src_a < src_b);
            OP_PASSB: alu_y = src_b;
            default:  alu_y = '0;
        endcase
    end

    // Branch compare always uses the forwarded register operands, never PC/immediate.
    always_comb begin
        br_taken = 1'b0;
        case (bus.funct3E)
            3'b000:  br_taken = (src_af == src_bf);
            3'b001:  br_taken = (src_af != src_bf);
            3'b100:  br_taken = ($signed(src_af) <  $signed(src_bf));
            3'b101:  br_taken = ($signed(src_af) >= $signed(src_bf));
            3'b110:  br_taken = (src_af <  src_bf);
            3'b111:  br_taken = (src_af >= src_bf);
            default: br_taken = 1'b0;
        endcase
    end

    assign bus.PCSrcE    = bus.JumpE | bus.JalrE | (bus.BranchE & br_taken);
    assign bus.PCTargetE = bus.JalrE ? ((src_af + bus.ImmExtE) & ~DATA_W'(1)) : (bus.PCE + bus.ImmExtE);
    assign bus.StallX    = stall;

`ifdef MULDIV_EN
    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t         md_state, md_state_nx;
    logic [CNT_W-1:0]  md_count;
    logic [2:0]        md_op;
    logic [ACC_W-1:0]  md_acc, md_acc_nx, md_prod;
    logic [DATA_W-1:0] md_opb, md_quo, md_rem, md_result, a_mag, b_mag, rem_diff;
    logic [DATA_W:0]   mul_sum, rem_sh;
    logic              md_neg_q, md_neg_r, md_div0, md_load, md_step, md_done;
    logic              a_signed, b_signed, a_neg, b_neg, rem_ge;

    // Work on magnitudes; MULHSU treats rs2 as unsigned, DIVU/REMU treat both as unsigned.
    assign a_signed = bus.funct3E[2] ? ~bus.funct3E[0] : (bus.funct3E[1:0] != 2'b11);
    assign b_signed = bus.funct3E[2] ? ~bus.funct3E[0] : ~bus.funct3E[1];
    assign a_neg    = a_signed & src_af[DATA_W-1];
    assign b_neg    = b_signed & src_bf[DATA_W-1];
    assign a_mag    = a_neg ? -src_af : src_af;
    assign b_mag    = b_neg ? -src_bf : src_bf;

    always_comb begin
        md_state_nx = md_state;
        stall       = 1'b0;
        md_load     = 1'b0;
        md_step     = 1'b0;
        md_done     = 1'b0;
        case (md_state)
            MD_IDLE: if (bus.MulDivE) begin
                stall       = 1'b1;
                md_load     = 1'b1;
                md_state_nx = MD_BUSY;
            end
            MD_BUSY: begin
                stall   = 1'b1;
                md_step = 1'b1;
                if (md_count == '0) md_state_nx = MD_DONE;
            end
            MD_DONE: begin
                md_done     = 1'b1;
                md_state_nx = MD_IDLE;
            end
            default: md_state_nx = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) md_state <= MD_IDLE;
        else        md_state <= md_state_nx;
    end

    // Multiply: {hi, multiplier} shift-add. Divide: {remainder, quotient} restoring shift-subtract.
    assign mul_sum   = {1'b0, md_acc[ACC_W-1:DATA_W]} + (md_acc[0] ? {1'b0, md_opb} : '0);
    assign rem_sh    = {md_acc[ACC_W-1:DATA_W], md_acc[DATA_W-1]};
    assign rem_ge    = (rem_sh >= {1'b0, md_opb});
    assign rem_diff  = DATA_W'(rem_sh - {1'b0, md_opb});
    assign md_acc_nx = md_op[2] ? (rem_ge ? {rem_diff, md_acc[DATA_W-2:0], 1'b1}
                                          : {rem_sh[DATA_W-1:0], md_acc[DATA_W-2:0], 1'b0})
                                : {mul_sum, md_acc[DATA_W-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_count <= '0;
            md_op    <= '0;
            md_acc   <= '0;
            md_opb   <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_div0  <= 1'b0;
        end else if (md_load) begin
            md_count <= CNT_W'(DATA_W - 1);
            md_op    <= bus.funct3E;
            md_acc   <= {{DATA_W{1'b0}}, a_mag};
            md_opb   <= b_mag;
            md_neg_q <= a_neg ^ b_neg;
            md_neg_r <= a_neg;
            md_div0  <= (src_bf == '0);
        end else if (md_step) begin
            md_acc   <= md_acc_nx;
            md_count <= md_count - CNT_W'(1);
        end
    end

    // Signed overflow falls out of the magnitude path; only divide-by-zero needs an override.
    assign md_prod = md_neg_q ? -md_acc : md_acc;
    assign md_quo  = md_div0 ? '1 : (md_neg_q ? -md_acc[DATA_W-1:0] : md_acc[DATA_W-1:0]);
    assign md_rem  = md_neg_r ? -md_acc[ACC_W-1:DATA_W] : md_acc[ACC_W-1:DATA_W];

    always_comb begin
        md_result = md_prod[DATA_W-1:0];
        if (md_op[2])                md_result = md_op[1] ? md_rem : md_quo;
        else if (md_op[1:0] != 2'b00) md_result = md_prod[ACC_W-1:DATA_W];
    end

    assign ex_result = md_done ? md_result : alu_y;
`else
    logic unused_muldiv;
    assign unused_muldiv = bus.MulDivE;
    assign stall         = 1'b0;
    assign ex_result     = alu_y;
`endif

    // EX/MEM register; a stall inserts a fully zeroed bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemReadM   <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.WriteBackM <= '0;
            bus.funct3M    <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCTargetM  <= '0;
            bus.PCPlus4M   <= '0;
            bus.ImmExtM    <= '0;
            bus.RdM        <= '0;
        end else if (stall) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemReadM   <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.WriteBackM <= '0;
            bus.funct3M    <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCTargetM  <= '0;
            bus.PCPlus4M   <= '0;
            bus.ImmExtM    <= '0;
            bus.RdM        <= '0;
        end else begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemReadM   <= bus.MemReadE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.WriteBackM <= bus.WriteBackE;
            bus.funct3M    <= bus.funct3E;
            bus.ALUResultM <= ex_result;
            bus.WriteDataM <= src_bf;
            bus.PCTargetM  <= bus.PCTargetE;
            bus.PCPlus4M   <= bus.PCPlus4E;
            bus.ImmExtM    <= bus.ImmExtE;
            bus.RdM        <= bus.RdE;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed stimulus for ex_stage, checked every cycle against a behavioural model.
// With MULDIV_EN defined, also exercises the multiply/divide unit against 64-bit arithmetic.
module tb_ex_stage;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7;

    logic clk, reset;
    int   total, bad;
    bit   chk_en;

    ex_stage_if #(.DATA_W(32), .ALU_CTRL_W(4)) bus ();
    ex_stage #(.DATA_W(32), .ALU_CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: expected EX/MEM contents (m_*) and the value about to be captured (n_*).
    logic        m_regw, m_memr, m_memw, n_regw, n_memr, n_memw;
    logic [2:0]  m_wb, m_f3, n_wb, n_f3;
    logic [4:0]  m_rd, n_rd;
    logic [31:0] m_alu, m_wd, m_tgt, m_pc4, m_imm, n_alu, n_wd, n_tgt, n_pc4, n_imm;
    logic [31:0] t_sa, t_sb, t_a, t_b, t_tgt;
    logic        t_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rd, input logic [31:0] wb,
                                            input logic [31:0] mres);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mres;
        return rd;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << s;
            4'd6:    return a >> s;
            4'd7:    return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return !($signed(a) < $signed(b));
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_model();
        m_regw = 0; m_memr = 0; m_memw = 0; m_wb = 0; m_f3 = 0; m_rd = 0;
        m_alu = 0; m_wd = 0; m_tgt = 0; m_pc4 = 0; m_imm = 0;
    endtask

    // Model + compare, combinational half: evaluated mid-cycle with inputs stable.
    always @(negedge clk) begin
        if (!reset) clear_model();
        if (chk_en) begin
            t_sa  = ref_fwd(bus.ForwardAE, bus.RD1E, bus.ResultW, m_alu);
            t_sb  = ref_fwd(bus.ForwardBE, bus.RD2E, bus.ResultW, m_alu);
            t_a   = bus.ALUSrcAE ? bus.PCE : t_sa;
            t_b   = bus.ALUSrcBE ? bus.ImmExtE : t_sb;
            t_src = bus.JumpE | bus.JalrE | (bus.BranchE & ref_taken(bus.funct3E, t_sa, t_sb));
            t_tgt = bus.JalrE ? ((t_sa + bus.ImmExtE) & 32'hFFFF_FFFE) : (bus.PCE + bus.ImmExtE);
            chk("pcsrc", 32'(bus.PCSrcE), 32'(t_src));
            chk("pctarget", bus.PCTargetE, t_tgt);
            chk("stallx", 32'(bus.StallX), 32'd0);
            n_regw = bus.RegWriteE; n_memr = bus.MemReadE; n_memw = bus.MemWriteE;
            n_wb = bus.WriteBackE; n_f3 = bus.funct3E; n_rd = bus.RdE;
            n_alu = ref_alu(bus.ALUControlE, t_a, t_b); n_wd = t_sb; n_tgt = t_tgt;
            n_pc4 = bus.PCPlus4E; n_imm = bus.ImmExtE;
        end
    end

    // Model + compare, registered half: checked just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            if (!reset) clear_model();
            else begin
                m_regw = n_regw; m_memr = n_memr; m_memw = n_memw; m_wb = n_wb; m_f3 = n_f3; m_rd = n_rd;
                m_alu = n_alu; m_wd = n_wd; m_tgt = n_tgt; m_pc4 = n_pc4; m_imm = n_imm;
            end
            chk("RegWriteM", 32'(bus.RegWriteM), 32'(m_regw));
            chk("MemReadM", 32'(bus.MemReadM), 32'(m_memr));
            chk("MemWriteM", 32'(bus.MemWriteM), 32'(m_memw));
            chk("WriteBackM", 32'(bus.WriteBackM), 32'(m_wb));
            chk("funct3M", 32'(bus.funct3M), 32'(m_f3));
            chk("RdM", 32'(bus.RdM), 32'(m_rd));
            chk("ALUResultM", bus.ALUResultM, m_alu);
            chk("WriteDataM", bus.WriteDataM, m_wd);
            chk("PCTargetM", bus.PCTargetM, m_tgt);
            chk("PCPlus4M", bus.PCPlus4M, m_pc4);
            chk("ImmExtM", bus.ImmExtM, m_imm);
        end
    end

    task automatic clear_inputs();
        bus.RegWriteE = 0; bus.MemReadE = 0; bus.MemWriteE = 0; bus.WriteBackE = 0; bus.funct3E = 0;
        bus.ALUControlE = 0; bus.ALUSrcAE = 0; bus.ALUSrcBE = 0; bus.BranchE = 0; bus.JumpE = 0;
        bus.JalrE = 0; bus.MulDivE = 0; bus.RD1E = 0; bus.RD2E = 0; bus.PCE = 0; bus.ImmExtE = 0;
        bus.PCPlus4E = 0; bus.RdE = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
    endtask

    task automatic rand_inputs();
        bus.RegWriteE = 1'($urandom); bus.MemReadE = 1'($urandom); bus.MemWriteE = 1'($urandom);
        bus.WriteBackE = 3'($urandom); bus.funct3E = 3'($urandom); bus.ALUControlE = 4'($urandom);
        bus.ALUSrcAE = 1'($urandom); bus.ALUSrcBE = 1'($urandom); bus.BranchE = 1'($urandom);
        bus.JumpE = ($urandom_range(0, 7) == 0); bus.JalrE = ($urandom_range(0, 7) == 0);
`ifdef MULDIV_EN
        bus.MulDivE = 1'b0;
`else
        bus.MulDivE = 1'($urandom);
`endif
        bus.RD1E = $urandom; bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.ResultW = $urandom;
        bus.RD2E = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
        bus.ImmExtE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        bus.RdE = 5'($urandom); bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

`ifdef MULDIV_EN
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000
                                                  : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    task automatic md_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit has_lit, input logic [31:0] lit);
        int n;
        clear_inputs();
        bus.MulDivE = 1; bus.funct3E = f3; bus.RD1E = a; bus.RD2E = b; bus.RegWriteE = 1; bus.RdE = 5'd9;
        n = 0;
        @(negedge clk); #1;
        while (bus.StallX === 1'b1 && n < 100) begin
            n++;
            step();
            chk("md_bubble_regwrite", 32'(bus.RegWriteM), 32'd0);
            @(negedge clk); #1;
        end
        chk("md_stall_cycles", 32'(n), 32'd33);
        step();
        chk("md_result_model", bus.ALUResultM, ref_md(f3, a, b));
        if (has_lit) chk("md_result_literal", bus.ALUResultM, lit);
        chk("md_regwrite", 32'(bus.RegWriteM), 32'd1);
        chk("md_rd", 32'(bus.RdM), 32'd9);
        clear_inputs();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; chk_en = 1; reset = 0;
        clear_inputs();
        #12;
        chk("reset_alu", bus.ALUResultM, 32'h0);
        chk("reset_regwrite", 32'(bus.RegWriteM), 32'd0);
        @(posedge clk); #2;
        reset = 1;
        repeat (10) begin rand_inputs(); step(); end

        // Reset mid-flow, then ADD 5+7 to r3.
        clear_inputs();
        bus.RegWriteE = 1; bus.RD1E = 5; bus.RD2E = 7; bus.RdE = 3; bus.ALUControlE = ADD;
        step();
        chk("add_pre_reset", bus.ALUResultM, 32'd12);
        #1 reset = 0;
        #1;
        chk("async_reset_alu", bus.ALUResultM, 32'h0);
        chk("async_reset_rd", 32'(bus.RdM), 32'd0);
        chk("async_reset_regwrite", 32'(bus.RegWriteM), 32'd0);
        @(posedge clk); #2;
        reset = 1;
        step();
        chk("add_result", bus.ALUResultM, 32'd12);
        chk("add_rd", 32'(bus.RdM), 32'd3);

        // Forwarding from the EX/MEM register and from write-back.
        bus.RD1E = 32'h10; bus.RD2E = 0;
        step();
        chk("fwd_setup", bus.ALUResultM, 32'h10);
        bus.ALUControlE = SUB; bus.ForwardAE = 2'b10; bus.RD1E = 32'hDEAD_0000; bus.RD2E = 1;
        step();
        chk("fwd_m_sub", bus.ALUResultM, 32'h0F);
        clear_inputs();
        bus.ForwardBE = 2'b01; bus.ResultW = 32'hAA; bus.RD2E = 32'h55; bus.MemWriteE = 1;
        bus.ALUSrcBE = 1; bus.ImmExtE = 8; bus.RD1E = 32'h100;
        step();
        chk("fwd_w_store_data", bus.WriteDataM, 32'hAA);
        chk("store_addr", bus.ALUResultM, 32'h108);

        // Branch and JALR resolution.
        clear_inputs();
        bus.BranchE = 1; bus.funct3E = 3'b100; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1;
        bus.PCE = 32'h1000; bus.ImmExtE = 32'h20;
        @(negedge clk); #1;
        chk("blt_taken", 32'(bus.PCSrcE), 32'd1);
        chk("blt_target", bus.PCTargetE, 32'h1020);
        step();
        bus.funct3E = 3'b110;
        @(negedge clk); #1;
        chk("bltu_not_taken", 32'(bus.PCSrcE), 32'd0);
        step();
        bus.funct3E = 3'b010;
        @(negedge clk); #1;
        chk("f3_010_never", 32'(bus.PCSrcE), 32'd0);
        step();
        clear_inputs();
        bus.JalrE = 1; bus.RD1E = 32'h103; bus.ImmExtE = 0;
        @(negedge clk); #1;
        chk("jalr_taken", 32'(bus.PCSrcE), 32'd1);
        chk("jalr_target", bus.PCTargetE, 32'h102);
        step();
        chk("jalr_target_m", bus.PCTargetM, 32'h102);

        // Shifts, including an amount above 31.
        clear_inputs();
        bus.RD1E = 32'h8000_0000; bus.ALUSrcBE = 1; bus.ImmExtE = 4; bus.ALUControlE = SRA;
        step();
        chk("sra", bus.ALUResultM, 32'hF800_0000);
        bus.ALUControlE = SRL;
        step();
        chk("srl", bus.ALUResultM, 32'h0800_0000);
        bus.ImmExtE = 33;
        step();
        chk("srl_by_33", bus.ALUResultM, 32'h4000_0000);
        bus.ALUControlE = SLL; bus.RD1E = 1;
        step();
        chk("sll_by_33", bus.ALUResultM, 32'h2);

        repeat (300) begin rand_inputs(); step(); end

`ifdef MULDIV_EN
        clear_inputs();
        chk_en = 0;
        step();
        md_run(3'd0, 32'hFFFF_FFFF, 32'd3, 1, 32'hFFFF_FFFD);
        md_run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        md_run(3'd5, 32'd7, 32'd0, 1, 32'hFFFF_FFFF);
        md_run(3'd6, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);
        for (int i = 0; i < 8; i++)
            md_run(3'(i), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 0, 32'h0);

        // Reset during BUSY must abort without emitting a result.
        bus.MulDivE = 1; bus.funct3E = 3'd4; bus.RD1E = 32'd100; bus.RD2E = 32'd7; bus.RegWriteE = 1;
        repeat (10) @(posedge clk);
        #3 reset = 0;
        #1;
        chk("md_abort_stall", 32'(bus.StallX), 32'd0);
        chk("md_abort_regwrite", 32'(bus.RegWriteM), 32'd0);
        clear_inputs();
        @(posedge clk); #2;
        reset = 1;
        repeat (40) begin
            step();
            chk("md_abort_no_result", bus.ALUResultM, 32'h0);
            chk("md_abort_no_write", 32'(bus.RegWriteM), 32'd0);
            chk("md_abort_idle", 32'(bus.StallX), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline. Sits between the ID/EX register and the memory stage.
- Performs operand forwarding, ALU operation, branch/jump resolution and target computation.
- Contains the EX/MEM pipeline register, whose outputs feed the memory stage directly.
- Optionally adds an iterative RV32M multiply/divide unit that stalls the front of the pipeline while busy.

Parameters:
- DATA_W, 32: datapath width; only 32 is supported.
- ALU_CTRL_W, 4: width of the ALU control field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWriteE, MemReadE, MemWriteE  in  1 each  ID/EX control bits.
- WriteBackE  in  3  write-back select, passed through.
- funct3E  in  3  branch condition / memory size / muldiv op.
- ALUControlE  in  4  ALU operation.
- ALUSrcAE  in  1  0 = forwarded rs1, 1 = PCE (AUIPC).
- ALUSrcBE  in  1  0 = forwarded rs2, 1 = ImmExtE.
- BranchE, JumpE, JalrE  in  1 each  control-flow class.
- MulDivE  in  1  RV32M instruction; ignored unless MULDIV_EN is defined.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  32 each  ID/EX data.
- RdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE.
- ResultW  in  32  write-back value.
- PCSrcE  out  1  redirect fetch; combinational.
- PCTargetE  out  32  redirect target; combinational.
- StallX  out  1  MulDiv busy; hold IF/ID/EX. Constant 0 without MULDIV_EN.
- RegWriteM, MemReadM, MemWriteM  out  1 each  registered.
- WriteBackM, funct3M  out  3 each  registered.
- ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM  out  32 each  registered.
- RdM  out  5  registered.

Behaviour:
- Reset (reset = 0, asynchronous): every registered output is 0. The MulDiv FSM returns to IDLE. Reset mid-operation aborts the operation with no partial result emitted.
- Forwarding: SrcAF and SrcBF are selected per ForwardAE/ForwardBE. ALUResultM is taken from this block's own register output.
- ALU operands:
  - SrcA = ALUSrcAE ? PCE : SrcAF.
  - SrcB = ALUSrcBE ? ImmExtE : SrcBF.
- ALUControlE encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[4:0].
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 PASS_B (LUI).
  - Any other code gives 0.
  - All arithmetic wraps modulo 2^32.
- Branch condition uses SrcAF vs SrcBF, keyed by funct3E:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- PCSrcE = JumpE | JalrE | (BranchE & cond).
- PCTargetE = JalrE ? ((SrcAF + ImmExtE) & ~1) : (PCE + ImmExtE).
- EX/MEM register: one-cycle latency. Each clock captures ALU (or MulDiv) result, WriteDataM = SrcBF, PCTargetE, PCPlus4E, ImmExtE, RdE and the control bits.
- Bubble: while StallX = 1, the register captures a bubble. All control bits and RdM are 0; data fields are don't-care and must be zeroed.

Optional Feature:
- Macro: MULDIV_EN.
- When defined, a MulDiv FSM IDLE -> BUSY -> DONE -> IDLE executes instructions with MulDivE = 1.
  - IDLE: a MulDiv instruction in EX moves the FSM to BUSY, loads operands and sets count = 31.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After 32 steps, go to DONE.
  - DONE: the result is captured into EX/MEM with the instruction's control bits, then back to IDLE.
  - StallX = 1 from the first EX cycle through BUSY, 0 in DONE. Total EX occupancy is 34 cycles.
- funct3E selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- When undefined: MulDivE is ignored, StallX is tied to 0 and no FSM is synthesised.

Test Plan:
- Reset while ALU instructions flow -> all M outputs read 0 immediately; after release, ADD RD1E=5, RD2E=7, RdE=3 gives ALUResultM=12, RdM=3 one clock later.
- Forward-back: ForwardAE=10 with prior ALUResultM=0x10 and SUB with RD2E=1 -> ALUResultM=0x0F; ForwardBE=01, ResultW=0xAA, MemWriteE=1 -> WriteDataM=0xAA.
- Branch sweep: BLT with SrcAF=0xFFFFFFFF, SrcBF=1 -> PCSrcE=1; BLTU with the same operands -> PCSrcE=0; JALR with SrcAF=0x103, Imm=0 -> PCTargetE=0x102.
- Shifts: SRA on 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000; a shift amount of 33 is taken as 1.
- MULDIV_EN, MUL 0xFFFFFFFF*3 -> StallX held 33 cycles, then ALUResultM=0xFFFFFFFD; bubbles with RegWriteM=0 during the stall.
- MULDIV_EN, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIVU 7/0 -> 0xFFFFFFFF; reset asserted mid-BUSY -> StallX=0 and no result emitted.
